// File: rtl/exec_controller.sv
// Instruction sequencer for the 8-bit accumulator CPU: two-byte fetch, execute,
// and accumulator/memory update over a shared 8-bit memory bus.
module exec_controller #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic [2:0]        alu_op,
    output logic [7:0]        alu_in,
    input  logic [7:0]        alu_result,
    output logic [7:0]        accum,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned IADDR_W = 13;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_LDO = 3'b001;
    localparam logic [OP_W-1:0] OP_LDA = 3'b010;
    localparam logic [OP_W-1:0] OP_STO = 3'b011;
    localparam logic [OP_W-1:0] OP_PRE = 3'b100;
    localparam logic [OP_W-1:0] OP_ADD = 3'b101;
    localparam logic [OP_W-1:0] OP_LDM = 3'b110;
    localparam logic [OP_W-1:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        EXEC,
        HALT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   ir_hi;
    logic [DATA_W-1:0]   ir_lo;
    logic [OP_W-1:0]     opcode;
    logic [ADDR_W-1:0]   ir_addr;
    logic                is_read;
    logic                is_write;

    assign opcode    = ir_hi[7:5];
    assign ir_addr   = ADDR_W'({ir_hi[4:0], ir_lo});
    assign mem_wdata = accum;
    assign alu_in    = mem_rdata;
    assign halted    = (state == HALT);

    // Opcode class decode
    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        case (opcode)
            OP_LDO, OP_LDA, OP_PRE, OP_ADD: is_read  = 1'b1;
            OP_STO, OP_LDM:                 is_write = 1'b1;
            default: ;
        endcase
    end

    // Bus strobes, address and ALU op; gated by rst so strobes drop without a clock edge
    always_comb begin
        mem_addr = pc;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        alu_op   = OP_NOP;
        if (!rst) begin
            case (state)
                FETCH_HI, FETCH_LO: mem_rd = 1'b1;
                EXEC: begin
                    mem_addr = ir_addr;
                    alu_op   = opcode;
                    mem_rd   = is_read;
                    mem_wr   = is_write;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state and architectural registers; a strobed cycle without mem_ready changes nothing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_HI;
            pc    <= '0;
            accum <= '0;
            ir_hi <= '0;
            ir_lo <= '0;
        end else begin
            case (state)
                FETCH_HI: begin
                    if (mem_ready) begin
                        ir_hi <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        ir_lo <= mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_read) begin
                        if (mem_ready) begin
                            accum <= alu_result;
                            state <= FETCH_HI;
                        end
                    end else if (is_write) begin
                        if (mem_ready) begin
                            state <= FETCH_HI;
                        end
                    end else if (opcode == OP_HLT) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH_HI;
                    end
                end
                HALT: ;
                default: state <= FETCH_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: expected bus cycles and halt entries are
// queued by the stimulus and matched by a monitor sampling on the falling edge.
module tb_exec_controller;

    typedef struct packed {
        logic [1:0]  kind;   // 0 read, 1 write, 2 halt entry, 3 both strobes
        logic        rdy;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [2:0]  op;
        logic [15:0] cyc;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [12:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [2:0]  alu_op;
    logic [7:0]  alu_in;
    logic [7:0]  alu_result;
    logic [7:0]  accum;
    logic [12:0] pc;
    logic        halted;

    logic [7:0]  mem [0:8191];
    ev_t         q[$];
    int          n_cmp;
    int          n_bad;
    logic [15:0] edges;
    logic        halted_q;
    logic [12:0] hpc;
    logic [7:0]  hacc;

    exec_controller dut (
        .clk        (clk),
        .rst        (rst),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_in     (alu_in),
        .alu_result (alu_result),
        .accum      (accum),
        .pc         (pc),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns garbage while not ready so premature loads are visible
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;

    // Reference ALU: loads pass the operand, ADD wraps, everything else passes accum
    always_comb begin
        case (alu_op)
            3'b001, 3'b010, 3'b100: alu_result = alu_in;
            3'b101:                 alu_result = accum + alu_in;
            default:                alu_result = accum;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) edges <= '0;
        else     edges <= edges + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic ev(input int kind, input int rdy, input int addr, input int data, input int op, input int cyc);
        ev_t e;
        e.kind = 2'(kind);
        e.rdy  = 1'(rdy);
        e.addr = 13'(addr);
        e.data = 8'(data);
        e.op   = 3'(op);
        e.cyc  = 16'(cyc);
        q.push_back(e);
    endtask

    task automatic fe(input int addr, input int data, input int cyc);
        ev(0, 1, addr, data, 0, cyc);
    endtask

    task automatic observe(input ev_t got);
        ev_t want;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d rdy=%0d addr=%h data=%h op=%0d cyc=%0d want none",
                     got.kind, got.rdy, got.addr, got.data, got.op, got.cyc);
        end else begin
            want = q.pop_front();
            if (want.kind == 2'd2) begin
                hpc  = want.addr;
                hacc = want.data;
            end
            if (got !== want) begin
                n_bad++;
                $display("FAIL bus_event: got kind=%0d rdy=%0d addr=%h data=%h op=%0d cyc=%0d want kind=%0d rdy=%0d addr=%h data=%h op=%0d cyc=%0d",
                         got.kind, got.rdy, got.addr, got.data, got.op, got.cyc,
                         want.kind, want.rdy, want.addr, want.data, want.op, want.cyc);
            end
        end
    endtask

    // Monitor: every strobed cycle, every halt entry, and the frozen outputs while halted
    always @(negedge clk) begin
        ev_t got;
        if (!rst) begin
            if (mem_rd || mem_wr) begin
                got.kind = mem_wr ? (mem_rd ? 2'd3 : 2'd1) : 2'd0;
                got.rdy  = mem_ready;
                got.addr = mem_addr;
                got.data = mem_wdata;
                got.op   = alu_op;
                got.cyc  = edges + 16'd1;
                observe(got);
            end
            if (halted && !halted_q) begin
                got.kind = 2'd2;
                got.rdy  = 1'b1;
                got.addr = pc;
                got.data = accum;
                got.op   = alu_op;
                got.cyc  = edges;
                observe(got);
            end
            if (halted)
                check("halt_frozen", 32'({mem_rd, mem_wr, alu_op, pc, accum}),
                      32'({2'b00, 3'b000, hpc, hacc}));
        end
        halted_q = rst ? 1'b0 : halted;
    end

    // Called at posedge+2; leaves rst asserted, memory cleared, checks reset outputs
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_strobes", 32'({mem_rd, mem_wr, alu_op}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_regs", 32'({halted, pc, accum}), 32'd0);
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Drive mem_ready for n edges; bit k-1 of low_mask holds edge k not ready
    task automatic run(input int n, input logic [31:0] low_mask);
        for (int k = 1; k <= n; k++) begin
            mem_ready = (k > 32) ? 1'b1 : !low_mask[5'(k - 1)];
            @(posedge clk);
            #2;
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        halted_q  = 1'b0;
        hpc       = '0;
        hacc      = '0;
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #2;

        // LDA/ADD/STO/HLT program, then HALT hold with toggling mem_ready
        do_reset();
        mem[0] = 8'h40; mem[1] = 8'h10; mem[2] = 8'hA0; mem[3] = 8'h11;
        mem[4] = 8'h60; mem[5] = 8'h12; mem[6] = 8'hE0; mem[7] = 8'h00;
        mem[16] = 8'h25; mem[17] = 8'h1F;
        fe(0, 8'h00, 1); fe(1, 8'h00, 2); ev(0, 1, 13'h010, 8'h00, 2, 3);
        fe(2, 8'h25, 4); fe(3, 8'h25, 5); ev(0, 1, 13'h011, 8'h25, 5, 6);
        fe(4, 8'h44, 7); fe(5, 8'h44, 8); ev(1, 1, 13'h012, 8'h44, 3, 9);
        fe(6, 8'h44, 10); fe(7, 8'h44, 11); ev(2, 1, 13'h008, 8'h44, 0, 12);
        release_rst();
        run(12, 32'h0);
        run(20, 32'h000A_AAAA);

        // ADD wrap: 0xF0 + 0x20 -> 0x10
        do_reset();
        mem[0] = 8'h40; mem[1] = 8'h20; mem[2] = 8'hA0; mem[3] = 8'h21;
        mem[4] = 8'h60; mem[5] = 8'h22; mem[6] = 8'hE0; mem[7] = 8'h00;
        mem[32] = 8'hF0; mem[33] = 8'h20;
        fe(0, 8'h00, 1); fe(1, 8'h00, 2); ev(0, 1, 13'h020, 8'h00, 2, 3);
        fe(2, 8'hF0, 4); fe(3, 8'hF0, 5); ev(0, 1, 13'h021, 8'hF0, 5, 6);
        fe(4, 8'h10, 7); fe(5, 8'h10, 8); ev(1, 1, 13'h022, 8'h10, 3, 9);
        fe(6, 8'h10, 10); fe(7, 8'h10, 11); ev(2, 1, 13'h004 << 1, 8'h10, 0, 12);
        release_rst();
        run(14, 32'h0);

        // Wait states: 2 during FETCH_LO, 3 during LDA EXEC
        do_reset();
        mem[0] = 8'h40; mem[1] = 8'h30; mem[2] = 8'hE0; mem[3] = 8'h00;
        mem[48] = 8'h5A;
        fe(0, 8'h00, 1);
        ev(0, 0, 1, 8'h00, 0, 2); ev(0, 0, 1, 8'h00, 0, 3); fe(1, 8'h00, 4);
        ev(0, 0, 13'h030, 8'h00, 2, 5); ev(0, 0, 13'h030, 8'h00, 2, 6);
        ev(0, 0, 13'h030, 8'h00, 2, 7); ev(0, 1, 13'h030, 8'h00, 2, 8);
        fe(2, 8'h5A, 9); fe(3, 8'h5A, 10); ev(2, 1, 13'h004, 8'h5A, 0, 11);
        release_rst();
        run(14, 32'h0000_0076);

        // PC wrap: all-NOP memory runs to 0x1FFF and restarts at 0x0000
        do_reset();
        for (int k = 0; k < 4096; k++) begin
            fe(2 * k, 8'h00, 3 * k + 1);
            fe(2 * k + 1, 8'h00, 3 * k + 2);
        end
        fe(0, 8'h00, 12289);
        fe(1, 8'h00, 12290);
        release_rst();
        run(12291, 32'h0);

        // Reset asserted mid-cycle during a stalled STO
        do_reset();
        mem[0] = 8'h40; mem[1] = 8'h40; mem[2] = 8'h60; mem[3] = 8'h41;
        mem[64] = 8'h77;
        fe(0, 8'h00, 1); fe(1, 8'h00, 2); ev(0, 1, 13'h040, 8'h00, 2, 3);
        fe(2, 8'h77, 4); fe(3, 8'h77, 5); ev(1, 0, 13'h041, 8'h77, 3, 6);
        release_rst();
        run(5, 32'h0);
        mem_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        mem_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("post_rst_regs", 32'({pc, accum}), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
